matrix_exec_unit: RTL and testbench
===================================

Name: matrix_exec_unit

Overview:
- Execution stage that sits directly in front of main memory. It reads one or two 4x4x16 matrix operands over the memory port, applies one element-wise operation, and writes the 256-bit result back to a destination slot.
- A simple Start/Busy/Done handshake lets the top-level controller sequence matrix jobs (e.g. A+B into result slot 2).
- The block is the sole master of the memory port while Busy=1.

Parameters:
- ELEM_W, 16, element width in bits.
- DIM, 4, matrix rows and columns. Matrix word width = DIM*DIM*ELEM_W = 256.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  job request; sampled only in IDLE.
- Opcode  in  2  0=ADD, 1=SUB (A-B), 2=TRANSPOSE(A), 3=SCALE(A by Imm).
- SrcA  in  16  operand A address; [15:12] is the module select, [11:0] is the slot.
- SrcB  in  16  operand B address; used for ADD and SUB only.
- Dst  in  16  result address.
- Imm  in  16  scale factor for SCALE.
- Busy  out  1  high from the cycle after Start is accepted until DONE is left.
- Done  out  1  one-cycle pulse in the DONE state.
- Err  out  1  valid with Done; set when any address used by the job has [15:12] != 0.
- MemAddr  out  16  memory address.
- MemNRead  out  1  active-low read strobe.
- MemNWrite  out  1  active-low write strobe.
- MemWData  out  256  write data to memory.
- MemRData  in  256  read data from memory; registered by memory, valid the cycle after the read strobe.

Behaviour:
- Reset (synchronous):
  - State=IDLE.
  - Busy=0, Done=0, Err=0.
  - MemNRead=1, MemNWrite=1, MemAddr=0, MemWData=0.
  - Operand and result registers cleared.
- Reset mid-job: the job is abandoned. No write is issued after the reset edge. A write strobe already sampled by memory is not undone.
- Outputs are decoded from the registered state and job registers. Strobes are never both low in the same cycle.
- IDLE: if Start=1 at a clock edge, latch Opcode, SrcA, SrcB, Dst and Imm. Next state:
  - CHECK-fail path to DONE with Err=1, with no memory access, if any used address has [15:12] != 0.
  - Otherwise RD_A.
- RD_A: MemAddr=SrcA, MemNRead=0, for one cycle. Next state WAIT_A.
- WAIT_A: strobes idle; capture MemRData into regA at the end of the cycle. Next state is RD_B for ADD/SUB, otherwise EXEC.
- RD_B / WAIT_B: same as RD_A / WAIT_A, using SrcB and regB. WAIT_B goes to EXEC.
- EXEC: result register <= operation on the operands. Element [r][c] occupies bits ((r*DIM+c)*ELEM_W) upward.
  - ADD and SUB: per element, modulo 2^16 (wrap).
  - TRANSPOSE: out[r][c] = A[c][r].
  - SCALE: low 16 bits of A[r][c]*Imm, unsigned.
  - Next state WR.
- WR: MemAddr=Dst, MemNWrite=0, MemWData=result, for one cycle. Next state DONE.
- DONE: Done=1 for one cycle, Err holds the job status. Next state IDLE.
- Latency from the Start-sampling edge to Done high:
  - ADD/SUB: 7 cycles.
  - TRANSPOSE/SCALE: 5 cycles.
  - Error case: 1 cycle.
- Start while Busy is ignored; no queueing.
- Start may be reasserted in the cycle Done is high. It is sampled one cycle later in IDLE.
- Dst equal to SrcA or SrcB is legal. Operands are fully captured before WR.

Optional Feature:
- Macro MATRIX_SAT_EN.
- When defined: ADD clamps to 0xFFFF on unsigned overflow, SUB clamps to 0x0000 on underflow, and SCALE clamps to 0xFFFF if the product exceeds 16 bits.
- When undefined: all three wrap modulo 2^16.
- TRANSPOSE is unaffected in both cases.

Decomposition:
- Package matrix_pkg holds:
  - ELEM_W and DIM constants.
  - Typedef matrix_t as [DIM-1:0][DIM-1:0][ELEM_W-1:0].
  - Enum opcode_e (ADD, SUB, TRANSPOSE, SCALE).
  - Enum state_e (IDLE, RD_A, WAIT_A, RD_B, WAIT_B, EXEC, WR, DONE).
- One combinational sub-module, matrix_elem_alu: inputs matrix_t A, matrix_t B, Opcode and Imm; output matrix_t result. The MATRIX_SAT_EN logic lives there.

Test Plan:
- After reset, ADD with SrcA=0x0000, SrcB=0x0001, Dst=0x0002, memory preloaded with the standard matrices 0 and 1 -> Done 7 cycles after Start; slot 2 element[0][0]=0x000C and element[3][3]=0x001B; Err=0.
- SUB with SrcA=0x0000, SrcB=0x0001 -> element[0][0]: 0x0003-0x0009 = 0xFFFA without MATRIX_SAT_EN, 0x0000 with it.
- TRANSPOSE of slot 0 to slot 3 -> slot 3 [0][1] equals slot 0 [1][0]; no read strobe issued to SrcB; Done after 5 cycles.
- SCALE of slot 1 by Imm=0x1000, element 0x0017 -> 0x7000; element 0x002D (product 0x2D000) -> 0xD000 wrapped, or 0xFFFF with MATRIX_SAT_EN.
- Dst=0x1002 -> Done and Err=1 one cycle after Start; MemNRead and MemNWrite stay high throughout.
- Reset asserted during WAIT_B -> next cycle is IDLE with Busy=0; MemNWrite never goes low; slot at Dst unchanged. Start during Busy is ignored, and only one write is observed.

Source files
------------

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared types and constants for the matrix execution unit.
//   ELEM_W, DIM, MAT_W : element width, matrix dimension, matrix word width
//   matrix_t           : DIM x DIM array of ELEM_W-bit elements; element [r][c]
//                        occupies bits ((r*DIM+c)*ELEM_W) upward
//   opcode_e           : ADD, SUB (A-B), TRANSPOSE (A), SCALE (A by Imm)
//   state_e            : job sequencer states
//   addr_is_remote     : true when a module-select field addresses another module
// -----------------------------------------------------------------------------
package matrix_pkg;

    localparam int ELEM_W = 16;
    localparam int DIM    = 4;
    localparam int MAT_W  = DIM * DIM * ELEM_W;

    typedef logic [DIM-1:0][DIM-1:0][ELEM_W-1:0] matrix_t;

    typedef enum logic [1:0] {
        ADD       = 2'd0,
        SUB       = 2'd1,
        TRANSPOSE = 2'd2,
        SCALE     = 2'd3
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_A   = 3'd1,
        WAIT_A = 3'd2,
        RD_B   = 3'd3,
        WAIT_B = 3'd4,
        EXEC   = 3'd5,
        WR     = 3'd6,
        DONE   = 3'd7
    } state_e;

    // Takes only the module-select nibble [15:12] of an address.
    function automatic logic addr_is_remote(input logic [3:0] module_sel);
        return module_sel != 4'd0;
    endfunction

endpackage

// File: rtl/matrix_elem_alu.sv
// -----------------------------------------------------------------------------
// matrix_elem_alu
// Purely combinational element-wise operation on two matrix operands.
//   A, B    in  matrix_t  operands (B only used by ADD and SUB)
//   Opcode  in  opcode_e  operation select
//   Imm     in  ELEM_W    unsigned scale factor for SCALE
//   result  out matrix_t  operation result
// Build option: define MATRIX_SAT_EN to clamp ADD/SCALE to 0xFFFF on overflow
// and SUB to 0x0000 on underflow; otherwise all three wrap modulo 2^16.
// TRANSPOSE is the same in both builds.
// -----------------------------------------------------------------------------
module matrix_elem_alu
    import matrix_pkg::*;
(
    input  matrix_t           A,
    input  matrix_t           B,
    input  opcode_e           Opcode,
    input  logic [ELEM_W-1:0] Imm,
    output matrix_t           result
);

    function automatic logic [ELEM_W-1:0] elem_add(input logic [ELEM_W-1:0] a,
                                                   input logic [ELEM_W-1:0] b);
`ifdef MATRIX_SAT_EN
        logic [ELEM_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[ELEM_W] ? '1 : sum[ELEM_W-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [ELEM_W-1:0] elem_sub(input logic [ELEM_W-1:0] a,
                                                   input logic [ELEM_W-1:0] b);
`ifdef MATRIX_SAT_EN
        return (a < b) ? '0 : a - b;
`else
        return a - b;
`endif
    endfunction

    function automatic logic [ELEM_W-1:0] elem_scale(input logic [ELEM_W-1:0] a,
                                                     input logic [ELEM_W-1:0] k);
`ifdef MATRIX_SAT_EN
        logic [2*ELEM_W-1:0] prod;
        prod = {{ELEM_W{1'b0}}, a} * {{ELEM_W{1'b0}}, k};
        return (prod[2*ELEM_W-1:ELEM_W] != '0) ? '1 : prod[ELEM_W-1:0];
`else
        // Self-determined ELEM_W-bit multiply keeps only the low half.
        return a * k;
`endif
    endfunction

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the block leaves it unassigned and infers a latch.
        result = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                case (Opcode)
                    ADD:       result[r][c] = elem_add(A[r][c], B[r][c]);
                    SUB:       result[r][c] = elem_sub(A[r][c], B[r][c]);
                    TRANSPOSE: result[r][c] = A[c][r];
                    SCALE:     result[r][c] = elem_scale(A[r][c], Imm);
                    default:   result[r][c] = '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/matrix_exec_unit.sv
// -----------------------------------------------------------------------------
// matrix_exec_unit
// Memory-side execution stage: reads one or two 4x4x16 matrix operands, applies
// one element-wise operation and writes the 256-bit result to a destination.
// Sole master of the memory port while Busy is high.
//   Clk        in   rising-edge clock
//   Reset      in   synchronous, active-high reset
//   Start      in   job request, sampled only in IDLE
//   Opcode     in   0=ADD 1=SUB 2=TRANSPOSE 3=SCALE
//   SrcA/SrcB  in   operand addresses ([15:12] module select, [11:0] slot)
//   Dst        in   result address
//   Imm        in   scale factor for SCALE
//   Busy       out  job in progress (any state other than IDLE)
//   Done       out  one-cycle completion pulse
//   Err        out  valid with Done: a used address selected another module
//   MemAddr    out  memory address
//   MemNRead   out  active-low read strobe
//   MemNWrite  out  active-low write strobe
//   MemWData   out  write data
//   MemRData   in   read data, valid the cycle after the read strobe
// Build option: MATRIX_SAT_EN selects saturating arithmetic in matrix_elem_alu.
// -----------------------------------------------------------------------------
module matrix_exec_unit
    import matrix_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Opcode,
    input  logic [15:0]      SrcA,
    input  logic [15:0]      SrcB,
    input  logic [15:0]      Dst,
    input  logic [15:0]      Imm,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [15:0]      MemAddr,
    output logic             MemNRead,
    output logic             MemNWrite,
    output logic [MAT_W-1:0] MemWData,
    input  logic [MAT_W-1:0] MemRData
);

    state_e      state;
    state_e      state_next;
    opcode_e     op_q;
    logic [15:0] src_a_q;
    logic [15:0] src_b_q;
    logic [15:0] dst_q;
    logic [15:0] imm_q;
    logic        err_q;
    matrix_t     reg_a;
    matrix_t     reg_b;
    matrix_t     result_q;
    matrix_t     alu_result;

    opcode_e     op_in;
    logic        uses_b_in;
    logic        bad_addr_in;

    // Address check is done on the live inputs in the Start cycle so an
    // illegal job goes straight to DONE without touching memory. SrcB only
    // counts for the two-operand operations.
    assign op_in       = opcode_e'(Opcode);
    assign uses_b_in   = (op_in == ADD) || (op_in == SUB);
    assign bad_addr_in = addr_is_remote(SrcA[15:12])
                       | addr_is_remote(Dst[15:12])
                       | (uses_b_in & addr_is_remote(SrcB[15:12]));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = bad_addr_in ? DONE : RD_A;
            RD_A:    state_next = WAIT_A;
            WAIT_A:  state_next = ((op_q == ADD) || (op_q == SUB)) ? RD_B : EXEC;
            RD_B:    state_next = WAIT_B;
            WAIT_B:  state_next = EXEC;
            EXEC:    state_next = WR;
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (Reset) begin
            state    <= IDLE;
            op_q     <= ADD;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            imm_q    <= '0;
            err_q    <= 1'b0;
            // NOTE: the wide operand/result registers are flops, not a RAM, so
            // clearing them on reset is cheap and keeps MemWData defined.
            reg_a    <= '0;
            reg_b    <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_q    <= op_in;
                        src_a_q <= SrcA;
                        src_b_q <= SrcB;
                        dst_q   <= Dst;
                        imm_q   <= Imm;
                        err_q   <= bad_addr_in;
                    end
                end
                WAIT_A:  reg_a    <= MemRData;
                WAIT_B:  reg_b    <= MemRData;
                EXEC:    result_q <= alu_result;
                default: ;
            endcase
        end
    end

    matrix_elem_alu u_alu (
        .A      (reg_a),
        .B      (reg_b),
        .Opcode (op_q),
        .Imm    (imm_q),
        .result (alu_result)
    );

    // Port outputs are decoded from registered state only; each strobe is
    // tied to a distinct state, so both can never be low together.
    always_comb begin
        MemAddr   = '0;
        MemNRead  = 1'b1;
        MemNWrite = 1'b1;
        MemWData  = '0;
        case (state)
            RD_A: begin
                MemAddr  = src_a_q;
                MemNRead = 1'b0;
            end
            RD_B: begin
                MemAddr  = src_b_q;
                MemNRead = 1'b0;
            end
            WR: begin
                MemAddr   = dst_q;
                MemNWrite = 1'b0;
                MemWData  = result_q;
            end
            default: ;
        endcase
    end

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);
    assign Err  = (state == DONE) & err_q;

endmodule

// File: tb/tb_matrix_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_matrix_exec_unit
// Directed bench for matrix_exec_unit with a registered-read memory model.
// Slot 0 holds A[r][c] = 3 + 4r + c; slot 1 holds the B_VALS table.
// Expected saturating values are selected with MATRIX_SAT_EN.
// -----------------------------------------------------------------------------
module tb_matrix_exec_unit;
    import matrix_pkg::*;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [1:0]       Opcode;
    logic [15:0]      SrcA;
    logic [15:0]      SrcB;
    logic [15:0]      Dst;
    logic [15:0]      Imm;
    logic             Busy;
    logic             Done;
    logic             Err;
    logic [15:0]      MemAddr;
    logic             MemNRead;
    logic             MemNWrite;
    logic [MAT_W-1:0] MemWData;
    logic [MAT_W-1:0] MemRData = '0;

    int compared   = 0;
    int mismatched = 0;

    matrix_exec_unit dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Opcode    (Opcode),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Dst       (Dst),
        .Imm       (Imm),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .MemAddr   (MemAddr),
        .MemNRead  (MemNRead),
        .MemNWrite (MemNWrite),
        .MemWData  (MemWData),
        .MemRData  (MemRData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- memory model ----------------
    logic [MAT_W-1:0] mem [0:7];
    int               read_count  = 0;
    int               write_count = 0;
    logic             both_low    = 1'b0;
    logic             pre_we      = 1'b0;
    logic [2:0]       pre_slot    = '0;
    logic [MAT_W-1:0] pre_data    = '0;

    always @(posedge Clk) begin
        if (pre_we)
            mem[pre_slot] <= pre_data;
        else if (!MemNWrite)
            mem[MemAddr[2:0]] <= MemWData;
        if (!MemNRead) begin
            MemRData   <= mem[MemAddr[2:0]];
            read_count <= read_count + 1;
        end
        if (!MemNWrite)
            write_count <= write_count + 1;
        if (!MemNRead && !MemNWrite)
            both_low <= 1'b1;
    end

    // ---------------- helpers ----------------
    localparam logic [15:0] B_VALS [16] = '{
        16'h0009, 16'h0017, 16'h002D, 16'h0040,
        16'h0005, 16'h0006, 16'h0007, 16'h0008,
        16'hFFFF, 16'h8000, 16'h0001, 16'h0002,
        16'h0010, 16'h0020, 16'h0030, 16'h0009
    };
    localparam logic [MAT_W-1:0] SENTINEL = {16{16'hA5A5}};

    function automatic matrix_t mk_a();
        matrix_t m;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                m[r][c] = 16'(3 + 4 * r + c);
        return m;
    endfunction

    function automatic matrix_t mk_b();
        matrix_t m;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                m[r][c] = B_VALS[r * DIM + c];
        return m;
    endfunction

    function automatic logic [15:0] elem(input int slot, input int r, input int c);
        matrix_t m;
        m = mem[slot];
        return m[r][c];
    endfunction

    task automatic check(input string tag, input logic [MAT_W-1:0] actual,
                         input logic [MAT_W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic poke(input int slot, input logic [MAT_W-1:0] data);
        @(negedge Clk);
        pre_we   = 1'b1;
        pre_slot = 3'(slot);
        pre_data = data;
        @(negedge Clk);
        pre_we   = 1'b0;
    endtask

    // Launches one job and counts clock edges from the Start-sampling edge
    // (edge 1) to the edge after which Done is high. lat stays 0 on timeout.
    task automatic run_job(input logic [1:0] op, input logic [15:0] sa,
                           input logic [15:0] sb, input logic [15:0] d,
                           input logic [15:0] imm, input int hold,
                           output int lat, output logic err,
                           output int rds, output int wrs);
        int r0;
        int w0;
        int guard;
        guard = 0;
        @(negedge Clk);
        while (Busy && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
        r0     = read_count;
        w0     = write_count;
        Opcode = op;
        SrcA   = sa;
        SrcB   = sb;
        Dst    = d;
        Imm    = imm;
        Start  = 1'b1;
        lat    = 0;
        err    = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge Clk);
            #1;
            if (i >= hold) Start = 1'b0;
            if (Done) begin
                lat = i;
                err = Err;
                break;
            end
        end
        Start = 1'b0;
        rds   = read_count - r0;
        wrs   = write_count - w0;
    endtask

    // ---------------- stimulus ----------------
    int   lat;
    logic err;
    int   rds;
    int   wrs;
    int   w_snap;

    initial begin
        Reset  = 1'b1;
        Start  = 1'b0;
        Opcode = '0;
        SrcA   = '0;
        SrcB   = '0;
        Dst    = '0;
        Imm    = '0;
        poke(0, mk_a());
        poke(1, mk_b());
        poke(5, SENTINEL);
        @(posedge Clk);
        #1;
        check("reset_busy",   Busy,      1'b0);
        check("reset_done",   Done,      1'b0);
        check("reset_err",    Err,       1'b0);
        check("reset_nread",  MemNRead,  1'b1);
        check("reset_nwrite", MemNWrite, 1'b1);
        check("reset_addr",   MemAddr,   16'h0000);
        check("reset_wdata",  MemWData,  '0);
        @(negedge Clk);
        Reset = 1'b0;

        // ADD slot0 + slot1 -> slot2
        run_job(ADD, 16'h0000, 16'h0001, 16'h0002, 16'h0000, 1, lat, err, rds, wrs);
        check("add_latency", lat, 7);
        check("add_err",     err, 1'b0);
        check("add_reads",   rds, 2);
        check("add_writes",  wrs, 1);
        check("add_00",      elem(2, 0, 0), 16'h000C);
        check("add_33",      elem(2, 3, 3), 16'h001B);
`ifdef MATRIX_SAT_EN
        check("add_20_ovf",  elem(2, 2, 0), 16'hFFFF);
`else
        check("add_20_ovf",  elem(2, 2, 0), 16'h000A);
`endif

        // SUB slot0 - slot1 -> slot4
        run_job(SUB, 16'h0000, 16'h0001, 16'h0004, 16'h0000, 1, lat, err, rds, wrs);
        check("sub_latency", lat, 7);
        check("sub_10",      elem(4, 1, 0), 16'h0002);
`ifdef MATRIX_SAT_EN
        check("sub_00_unf",  elem(4, 0, 0), 16'h0000);
        check("sub_03_unf",  elem(4, 0, 3), 16'h0000);
`else
        check("sub_00_unf",  elem(4, 0, 0), 16'hFFFA);
        check("sub_03_unf",  elem(4, 0, 3), 16'hFFC6);
`endif

        // TRANSPOSE slot0 -> slot3; SrcB must not be read
        run_job(TRANSPOSE, 16'h0000, 16'h0001, 16'h0003, 16'h0000, 1, lat, err, rds, wrs);
        check("tr_latency", lat, 5);
        check("tr_reads",   rds, 1);
        check("tr_01",      elem(3, 0, 1), 16'h0007);
        check("tr_30",      elem(3, 3, 0), 16'h0006);
        check("tr_22",      elem(3, 2, 2), 16'h000D);

        // SCALE slot1 by 0x1000 -> slot6; remote SrcB is unused, so no error
        run_job(SCALE, 16'h0001, 16'h5000, 16'h0006, 16'h1000, 1, lat, err, rds, wrs);
        check("sc_latency", lat, 5);
        check("sc_err",     err, 1'b0);
        check("sc_00",      elem(6, 0, 0), 16'h9000);
        check("sc_22",      elem(6, 2, 2), 16'h1000);
`ifdef MATRIX_SAT_EN
        check("sc_01_ovf",  elem(6, 0, 1), 16'hFFFF);
        check("sc_02_ovf",  elem(6, 0, 2), 16'hFFFF);
`else
        check("sc_01_ovf",  elem(6, 0, 1), 16'h7000);
        check("sc_02_ovf",  elem(6, 0, 2), 16'hD000);
`endif

        // Remote destination: immediate Done with Err, no memory traffic
        run_job(ADD, 16'h0000, 16'h0001, 16'h1002, 16'h0000, 1, lat, err, rds, wrs);
        check("err_latency", lat, 1);
        check("err_flag",    err, 1'b1);
        check("err_reads",   rds, 0);
        check("err_writes",  wrs, 0);

        // Start held while Busy: one job, one write
        run_job(ADD, 16'h0000, 16'h0001, 16'h0007, 16'h0000, 4, lat, err, rds, wrs);
        w_snap = write_count;
        check("hold_latency", lat, 7);
        check("hold_writes",  wrs, 1);
        repeat (10) @(posedge Clk);
        #1;
        check("hold_no_rerun", write_count - w_snap, 0);
        check("hold_idle",     Busy, 1'b0);

        // Reset during WAIT_B: job abandoned, destination untouched
        @(negedge Clk);
        w_snap = write_count;
        Opcode = ADD;
        SrcA   = 16'h0000;
        SrcB   = 16'h0001;
        Dst    = 16'h0005;
        Start  = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_in_waitb_busy", Busy, 1'b1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("rst_mid_busy",   Busy,      1'b0);
        check("rst_mid_done",   Done,      1'b0);
        check("rst_mid_nwrite", MemNWrite, 1'b1);
        check("rst_mid_nread",  MemNRead,  1'b1);
        Reset = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        check("rst_mid_writes", write_count - w_snap, 0);
        check("rst_mid_slot5",  mem[5], SENTINEL);

        check("strobes_exclusive", both_low, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
